// File: rtl/axil_regif_bridge_if.sv
// axil_regif_bridge_if: AXI4-Lite bus bundle (AW, W, B, AR, R channels); master drives requests, slave drives readies and responses
interface axil_regif_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic awvalid;
  logic awready;
  logic [ADDR_W-1:0] awaddr;
  logic wvalid;
  logic wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic bvalid;
  logic bready;
  logic [1:0] bresp;
  logic arvalid;
  logic arready;
  logic [ADDR_W-1:0] araddr;
  logic rvalid;
  logic rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_regif_bridge.sv
// axil_regif_bridge: AXI4-Lite slave turning each write/read into a one-cycle pvalid/raddr_valid strobe to the controller
//   clk, rst_n (async active-low) ; axil : AXI4-Lite slave modport
//   pvalid/paddr/pdata + cwresp : controller write port, response sampled in the issue cycle
//   raddr_valid/raddr + c_rdata/crresp : controller read port, data sampled in the issue cycle
//   AXIL_BRIDGE_RD_WAIT_EN : two-cycle read issue, data sampled in the second cycle (registered LUT read)
module axil_regif_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  axil_regif_bridge_if.slave axil,
  output logic pvalid,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pdata,
  input  logic [1:0] cwresp,
  output logic raddr_valid,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic [1:0] crresp
);
  typedef enum logic [1:0] {W_COLLECT, W_ISSUE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic aw_held, w_held, w_full;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] w_data;
  logic aw_hs, w_hs, ar_hs, aw_done, w_done, nxt_full;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_data;
`ifdef AXIL_BRIDGE_RD_WAIT_EN
  logic r_wait;
`endif
  // a handshake in the same cycle the other half is already held issues straight away
  always_comb begin
    aw_hs = axil.awvalid & axil.awready;
    w_hs = axil.wvalid & axil.wready;
    ar_hs = axil.arvalid & axil.arready;
    aw_done = aw_held | aw_hs;
    w_done = w_held | w_hs;
    nxt_addr = aw_hs ? axil.awaddr : aw_addr;
    nxt_data = w_hs ? axil.wdata : w_data;
    nxt_full = w_hs ? &axil.wstrb : w_full;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_state <= W_COLLECT;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      w_full <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      axil.awready <= 1'b0;
      axil.wready <= 1'b0;
      axil.bvalid <= 1'b0;
      axil.bresp <= 2'b00;
      pvalid <= 1'b0;
      paddr <= '0;
      pdata <= '0;
    end else case (w_state)
      W_COLLECT: begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_addr <= axil.awaddr;
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= axil.wdata;
          w_full <= &axil.wstrb;
        end
        axil.awready <= !aw_done;
        axil.wready <= !w_done;
        if (aw_done && w_done) begin
          w_state <= W_ISSUE;
          pvalid <= nxt_full;
          // controller-facing address/data only move for a real strobe
          if (nxt_full) begin
            paddr <= nxt_addr;
            pdata <= nxt_data;
          end
        end
      end
      W_ISSUE: begin
        pvalid <= 1'b0;
        axil.bresp <= w_full ? cwresp : 2'b10;
        axil.bvalid <= 1'b1;
        w_state <= W_RESP;
      end
      W_RESP:
        if (axil.bready) begin
          axil.bvalid <= 1'b0;
          aw_held <= 1'b0;
          w_held <= 1'b0;
          axil.awready <= 1'b1;
          axil.wready <= 1'b1;
          w_state <= W_COLLECT;
        end
      default: w_state <= W_COLLECT;
    endcase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= R_IDLE;
      axil.arready <= 1'b0;
      axil.rvalid <= 1'b0;
      axil.rdata <= '0;
      axil.rresp <= 2'b00;
      raddr_valid <= 1'b0;
      raddr <= '0;
`ifdef AXIL_BRIDGE_RD_WAIT_EN
      r_wait <= 1'b0;
`endif
    end else case (r_state)
      R_IDLE:
        if (ar_hs) begin
          axil.arready <= 1'b0;
          raddr <= axil.araddr;
          raddr_valid <= 1'b1;
          r_state <= R_ISSUE;
        end else axil.arready <= 1'b1;
      R_ISSUE:
`ifdef AXIL_BRIDGE_RD_WAIT_EN
        if (!r_wait) r_wait <= 1'b1;
        else begin
          r_wait <= 1'b0;
          axil.rdata <= c_rdata;
          axil.rresp <= crresp;
          raddr_valid <= 1'b0;
          axil.rvalid <= 1'b1;
          r_state <= R_RESP;
        end
`else
        begin
          axil.rdata <= c_rdata;
          axil.rresp <= crresp;
          raddr_valid <= 1'b0;
          axil.rvalid <= 1'b1;
          r_state <= R_RESP;
        end
`endif
      R_RESP:
        if (axil.rready) begin
          axil.rvalid <= 1'b0;
          axil.arready <= 1'b1;
          r_state <= R_IDLE;
        end
      default: r_state <= R_IDLE;
    endcase
endmodule

// File: tb/tb_axil_regif_bridge.sv
// tb_axil_regif_bridge: scoreboard bench for axil_regif_bridge with a small register-file controller model
module tb_axil_regif_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  axil_regif_bridge_if #(.ADDR_W(32), .DATA_W(32)) axil ();
  logic pvalid, raddr_valid;
  logic [31:0] paddr, pdata, raddr, c_rdata;
  logic [1:0] cwresp, crresp;
  logic [1:0] cw_resp = 2'b00;
  axil_regif_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .axil(axil),
    .pvalid(pvalid), .paddr(paddr), .pdata(pdata), .cwresp(cwresp),
    .raddr_valid(raddr_valid), .raddr(raddr), .c_rdata(c_rdata), .crresp(crresp)
  );
  logic [31:0] ctl_regs [16];
  logic [31:0] shadow [16];
  logic ctl_clr = 1'b1;
  always @(posedge clk)
    if (ctl_clr) for (int i = 0; i < 16; i++) ctl_regs[i] <= '0;
    else if (pvalid) ctl_regs[paddr[15:12]] <= pdata;
  assign c_rdata = ctl_regs[raddr[15:12]];
  assign crresp = (raddr[15:12] == 4'hF) ? 2'b10 : 2'b00;
  assign cwresp = cw_resp;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int pv_cnt = 0;
  int pv_cyc = -1;
  int rv_cyc = -2;
  logic [63:0] exp_p [$];
  logic [1:0] exp_b [$];
  logic [33:0] exp_r [$];
  logic [63:0] mon_p;
  logic [33:0] mon_r;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (pvalid) begin
        pv_cnt++;
        pv_cyc = cyc;
        if (exp_p.size() == 0) check("pvalid_unexp", 1, 0);
        else begin
          mon_p = exp_p.pop_front();
          check("paddr", paddr, mon_p[63:32]);
          check("pdata", pdata, mon_p[31:0]);
        end
      end
      if (raddr_valid) rv_cyc = cyc;
      if (axil.bvalid && axil.bready) begin
        if (exp_b.size() == 0) check("b_unexp", 1, 0);
        else check("bresp", axil.bresp, exp_b.pop_front());
      end
      if (axil.rvalid && axil.rready) begin
        if (exp_r.size() == 0) check("r_unexp", 1, 0);
        else begin
          mon_r = exp_r.pop_front();
          check("rdata", axil.rdata, mon_r[33:2]);
          check("rresp", axil.rresp, mon_r[1:0]);
        end
      end
    end
  task automatic send_aw(input logic [31:0] a);
    bit ok = 1'b0;
    axil.awvalid = 1'b1;
    axil.awaddr = a;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = axil.awready;
    end
    @(posedge clk);
    #1 axil.awvalid = 1'b0;
    check("aw_hs", ok, 1);
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    axil.wvalid = 1'b1;
    axil.wdata = d;
    axil.wstrb = s;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = axil.wready;
    end
    @(posedge clk);
    #1 axil.wvalid = 1'b0;
    check("w_hs", ok, 1);
  endtask
  task automatic send_ar(input logic [31:0] a);
    bit ok = 1'b0;
    axil.arvalid = 1'b1;
    axil.araddr = a;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = axil.arready;
    end
    @(posedge clk);
    #1 axil.arvalid = 1'b0;
    check("ar_hs", ok, 1);
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] cw, input int aw_lag);
    int pv0;
    logic full;
    full = &s;
    pv0 = pv_cnt;
    cw_resp = cw;
    if (full) exp_p.push_back({a, d});
    exp_b.push_back(full ? cw : 2'b10);
    fork
      begin
        repeat (aw_lag) @(posedge clk);
        if (aw_lag > 0) #1;
        send_aw(a);
      end
      send_w(d, s);
    join
    @(negedge clk);
    check("pvalid_issue", pvalid, full);
    check("bvalid_early", axil.bvalid, 0);
    @(negedge clk);
    check("pvalid_once", pvalid, 0);
    check("bvalid_lat", axil.bvalid, 1);
    check("aw_blocked", axil.awready, 0);
    @(posedge clk);
    #1;
    check("pv_count", pv_cnt - pv0, full);
    if (full) shadow[a[15:12]] = d;
  endtask
  task automatic do_read(input logic [31:0] a, input int hold);
    logic [31:0] ed;
    logic [1:0] er;
    ed = shadow[a[15:12]];
    er = (a[15:12] == 4'hF) ? 2'b10 : 2'b00;
    exp_r.push_back({ed, er});
    axil.rready = (hold == 0);
    send_ar(a);
    @(negedge clk);
    check("rd_strobe", raddr_valid, 1);
    check("raddr", raddr, a);
`ifdef AXIL_BRIDGE_RD_WAIT_EN
    @(negedge clk);
    check("rd_strobe2", raddr_valid, 1);
`endif
    @(negedge clk);
    check("rd_strobe_end", raddr_valid, 0);
    check("rvalid_lat", axil.rvalid, 1);
    repeat (hold) begin
      check("r_bp_valid", axil.rvalid, 1);
      check("r_bp_data", axil.rdata, ed);
      check("r_bp_resp", axil.rresp, er);
      check("ar_blocked", axil.arready, 0);
      @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1 axil.rready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    axil.awvalid = 1'b0;
    axil.awaddr = '0;
    axil.wvalid = 1'b0;
    axil.wdata = '0;
    axil.wstrb = '0;
    axil.bready = 1'b1;
    axil.arvalid = 1'b0;
    axil.araddr = '0;
    axil.rready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", axil.awready, 0);
    check("rst_wready", axil.wready, 0);
    check("rst_arready", axil.arready, 0);
    check("rst_bvalid", axil.bvalid, 0);
    check("rst_rvalid", axil.rvalid, 0);
    check("rst_pvalid", pvalid, 0);
    check("rst_rstrobe", raddr_valid, 0);
    check("rst_bresp", axil.bresp, 0);
    check("rst_rresp", axil.rresp, 0);
    check("rst_rdata", axil.rdata, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pdata", pdata, 0);
    check("rst_raddr", raddr, 0);
    rst_n = 1'b1;
    ctl_clr = 1'b0;
    @(negedge clk);
    check("ready_pre_aw", axil.awready, 0);
    check("ready_pre_ar", axil.arready, 0);
    @(negedge clk);
    check("ready_aw", axil.awready, 1);
    check("ready_w", axil.wready, 1);
    check("ready_ar", axil.arready, 1);
    @(posedge clk);
    #1;
    do_write(32'h1000, 32'h5, 4'hF, 2'b00, 0);
    do_write(32'h9000, 32'hABCD, 4'hF, 2'b10, 3);
    do_write(32'h3000, 32'h33, 4'h3, 2'b00, 0);
    do_write(32'h3000, 32'h44, 4'hF, 2'b00, 0);
    do_write(32'h2000, 32'h1FF, 4'hF, 2'b00, 0);
    do_read(32'h2000, 4);
    do_read(32'h3000, 0);
    do_read(32'hF000, 0);
    fork
      do_write(32'h1000, 32'h77, 4'hF, 2'b00, 0);
      do_read(32'h1000, 0);
    join
    check("same_cycle_strobes", pv_cyc, rv_cyc);
    do_read(32'h1000, 0);
    axil.bready = 1'b0;
    axil.rready = 1'b0;
    exp_p.push_back({32'h7000, 32'hDEAD});
    shadow[7] = 32'hDEAD;
    fork
      send_aw(32'h7000);
      send_w(32'hDEAD, 4'hF);
    join
    send_ar(32'h7000);
    rst_n = 1'b0;
    #2;
    check("mid_bvalid", axil.bvalid, 0);
    check("mid_rvalid", axil.rvalid, 0);
    check("mid_rstrobe", raddr_valid, 0);
    check("mid_pvalid", pvalid, 0);
    check("mid_arready", axil.arready, 0);
    check("mid_raddr", raddr, 0);
    check("mid_paddr", paddr, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    axil.bready = 1'b1;
    axil.rready = 1'b1;
    @(negedge clk);
    check("post_pre_aw", axil.awready, 0);
    check("post_pre_ar", axil.arready, 0);
    @(negedge clk);
    check("post_aw", axil.awready, 1);
    check("post_w", axil.wready, 1);
    check("post_ar", axil.arready, 1);
    repeat (3) begin
      check("post_no_b", axil.bvalid, 0);
      check("post_no_r", axil.rvalid, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    do_write(32'h5000, 32'h55, 4'hF, 2'b00, 0);
    do_read(32'h7000, 0);
    do_read(32'h5000, 0);
    repeat (3) @(posedge clk);
    check("sb_p_empty", exp_p.size(), 0);
    check("sb_b_empty", exp_b.size(), 0);
    check("sb_r_empty", exp_r.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
